// File: rtl/timer_scheduler_pkg.sv
// Shared types and constants for the deadline scheduler
// that sits in front of the machine timer.
package timer_scheduler_pkg;

  localparam int NUM_TIMER_SLOTS = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXPIRE,
    S_SCAN,
    S_WR_HI_MAX,
    S_WR_LO,
    S_WR_HI
  } timer_sched_state_t;

  localparam logic [1:0] MTIME_ADDR_TIME_LO = 2'd0;
  localparam logic [1:0] MTIME_ADDR_TIME_HI = 2'd1;
  localparam logic [1:0] MTIME_ADDR_CMP_LO  = 2'd2;
  localparam logic [1:0] MTIME_ADDR_CMP_HI  = 2'd3;

  localparam logic [63:0] MTIMECMP_DISABLED = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/timer_slot_bank.sv
// Deadline/armed storage with a config write port, per-slot
// expiry compare and an indexed read port for the scanner.
module timer_slot_bank #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [SLOT_W-1:0]    wr_slot,
  input  logic                 wr_arm,
  input  logic [63:0]          wr_deadline,
  input  logic [NUM_SLOTS-1:0] expire_clr,
  input  logic [63:0]          now,
  input  logic [SLOT_W-1:0]    rd_idx,
  output logic [NUM_SLOTS-1:0] armed,
  output logic [NUM_SLOTS-1:0] expired,
  output logic                 rd_armed,
  output logic [63:0]          rd_deadline
);

  logic [63:0] deadline [NUM_SLOTS];

  // A config write to a slot overrides its expiry clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        deadline[i] <= '0;
      end
    end else begin
      armed <= armed & ~expire_clr;
      if (wr_en) begin
        armed[wr_slot] <= wr_arm;
        if (wr_arm) begin
          deadline[wr_slot] <= wr_deadline;
        end
      end
    end
  end

  always_comb begin
    expired = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      expired[i] = armed[i] && (deadline[i] <= now);
    end
  end

  assign rd_armed    = armed[rd_idx];
  assign rd_deadline = deadline[rd_idx];

endmodule

// File: rtl/timer_scheduler.sv
// Multiplexes one machine timer into NUM_SLOTS one-shot
// deadlines and owns the timer's compare-register bus port.
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_TIMER_SLOTS,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_wr_en,
  input  logic [SLOT_W-1:0]    cfg_slot,
  input  logic                 cfg_arm,
  input  logic [63:0]          cfg_deadline,
  input  logic [NUM_SLOTS-1:0] pend_clr,
  output logic [NUM_SLOTS-1:0] pending,
  output logic [NUM_SLOTS-1:0] armed,
  output logic                 irq,
  output logic                 busy,
  output logic                 mt_rd_en,
  output logic                 mt_wr_en,
  output logic [1:0]           mt_addr,
  output logic [31:0]          mt_wr_data,
  output logic [3:0]           mt_wr_strobe,
  input  logic [63:0]          mt_time,
  input  logic                 mt_irq
);

  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NUM_SLOTS - 1);

  timer_sched_state_t state, state_next;

  logic [SLOT_W-1:0]    idx;
  logic [63:0]          best;
  logic                 dirty;
  logic                 scan_entry;
  logic [NUM_SLOTS-1:0] expired;
  logic [NUM_SLOTS-1:0] expire_clr;
  logic [NUM_SLOTS-1:0] pend_set;
  logic [NUM_SLOTS-1:0] pend_next;
  logic [NUM_SLOTS-1:0] cfg_hit;
  logic                 rd_armed;
  logic [63:0]          rd_deadline;

  timer_slot_bank #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (cfg_wr_en),
    .wr_slot     (cfg_slot),
    .wr_arm      (cfg_arm),
    .wr_deadline (cfg_deadline),
    .expire_clr  (expire_clr),
    .now         (mt_time),
    .rd_idx      (idx),
    .armed       (armed),
    .expired     (expired),
    .rd_armed    (rd_armed),
    .rd_deadline (rd_deadline)
  );

  always_comb begin
    cfg_hit = '0;
    if (cfg_wr_en) begin
      cfg_hit[cfg_slot] = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    expire_clr = '0;
    pend_set   = '0;
    unique case (state)
      S_IDLE: begin
        if (mt_irq && |expired) begin
          state_next = S_EXPIRE;
        end else if (dirty) begin
          state_next = S_SCAN;
        end
      end
      S_EXPIRE: begin
        expire_clr = expired;
        pend_set   = expired & ~cfg_hit;
        state_next = S_SCAN;
      end
      S_SCAN: begin
        if (idx == LAST) begin
          state_next = S_WR_HI_MAX;
        end
      end
      S_WR_HI_MAX: state_next = S_WR_LO;
      S_WR_LO:     state_next = S_WR_HI;
      S_WR_HI:     state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  assign scan_entry = (state_next == S_SCAN) && (state != S_SCAN);
  assign pend_next  = (pending & ~pend_clr) | pend_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      dirty   <= 1'b0;
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      state   <= state_next;
      dirty   <= cfg_wr_en | (dirty & ~scan_entry);
      pending <= pend_next;
      irq     <= |pend_next;
    end
  end

  // Strict less-than keeps the lower index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      best <= '0;
    end else if (scan_entry) begin
      idx  <= '0;
      best <= MTIMECMP_DISABLED;
    end else if (state == S_SCAN) begin
      idx <= idx + 1'b1;
      if (rd_armed && (rd_deadline < best)) begin
        best <= rd_deadline;
      end
    end
  end

  // Bus outputs follow the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mt_wr_en   <= 1'b0;
      mt_addr    <= '0;
      mt_wr_data <= '0;
    end else begin
      mt_wr_en   <= 1'b0;
      mt_addr    <= '0;
      mt_wr_data <= '0;
      unique case (state_next)
        S_WR_HI_MAX: begin
          mt_wr_en   <= 1'b1;
          mt_addr    <= MTIME_ADDR_CMP_HI;
          mt_wr_data <= MTIMECMP_DISABLED[63:32];
        end
        S_WR_LO: begin
          mt_wr_en   <= 1'b1;
          mt_addr    <= MTIME_ADDR_CMP_LO;
          mt_wr_data <= best[31:0];
        end
        S_WR_HI: begin
          mt_wr_en   <= 1'b1;
          mt_addr    <= MTIME_ADDR_CMP_HI;
          mt_wr_data <= best[63:32];
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state != S_IDLE);
  assign mt_rd_en     = 1'b0;
  assign mt_wr_strobe = {4{mt_wr_en}};

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with a behavioural
// mtime/mtimecmp model and a slot-level reference model.
module tb_timer_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_wr_en;
  logic [1:0]    cfg_slot;
  logic          cfg_arm;
  logic [63:0]   cfg_deadline;
  logic [N-1:0]  pend_clr;
  logic [N-1:0]  pending;
  logic [N-1:0]  armed;
  logic          irq;
  logic          busy;
  logic          mt_rd_en;
  logic          mt_wr_en;
  logic [1:0]    mt_addr;
  logic [31:0]   mt_wr_data;
  logic [3:0]    mt_wr_strobe;
  logic [63:0]   mt_time;
  logic          mt_irq;

  timer_scheduler #(.NUM_SLOTS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_slot     (cfg_slot),
    .cfg_arm      (cfg_arm),
    .cfg_deadline (cfg_deadline),
    .pend_clr     (pend_clr),
    .pending      (pending),
    .armed        (armed),
    .irq          (irq),
    .busy         (busy),
    .mt_rd_en     (mt_rd_en),
    .mt_wr_en     (mt_wr_en),
    .mt_addr      (mt_addr),
    .mt_wr_data   (mt_wr_data),
    .mt_wr_strobe (mt_wr_strobe),
    .mt_time      (mt_time),
    .mt_irq       (mt_irq)
  );

  always #5 clk = ~clk;

  // Timer peripheral model: compare register and interrupt.
  logic [63:0] mtimecmp;
  assign mt_irq = (mt_time >= mtimecmp);

  always @(posedge clk or posedge rst) begin
    if (rst) mtimecmp <= '1;
    else if (mt_wr_en && mt_addr == 2'd2) mtimecmp[31:0] <= mt_wr_data;
    else if (mt_wr_en && mt_addr == 2'd3) mtimecmp[63:32] <= mt_wr_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slot-level reference model.
  logic [N-1:0] m_armed = '0;
  logic [63:0]  m_dl [N];
  logic [N-1:0] m_pend = '0;

  function automatic logic [63:0] model_min();
    logic [63:0] b = '1;
    for (int i = 0; i < N; i++)
      if (m_armed[i] && m_dl[i] < b) b = m_dl[i];
    return b;
  endfunction

  task automatic model_expire();
    for (int i = 0; i < N; i++)
      if (m_armed[i] && m_dl[i] <= mt_time) begin
        m_armed[i] = 1'b0;
        m_pend[i]  = 1'b1;
      end
  endtask

  // Compare process: protocol of the 3-write sequence plus
  // per-cycle output rules; completed cmp values are logged.
  logic [63:0] cmps [$];
  int          tri_cyc = 0;

  initial begin
    int          pos;
    logic [31:0] lo_w;
    pos = 0;
    lo_w = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pos = 0;
      end else begin
        chk("rd_en", 64'(mt_rd_en), 64'd0);
        chk("strobe", 64'(mt_wr_strobe),
            mt_wr_en ? 64'hF : 64'h0);
        chk("irq_or", 64'(irq), 64'(|pending));
        chk("wr_when_idle", 64'(mt_wr_en && !busy), 64'd0);
        if (mt_wr_en) begin
          if (pos == 0) begin
            chk("seq_hi_max", {30'd0, mt_addr, mt_wr_data},
                {30'd0, 2'd3, 32'hFFFF_FFFF});
            pos = 1;
          end else if (pos == 1) begin
            chk("seq_lo_addr", 64'(mt_addr), 64'd2);
            lo_w = mt_wr_data;
            pos = 2;
          end else begin
            chk("seq_hi_addr", 64'(mt_addr), 64'd3);
            cmps.push_back({mt_wr_data, lo_w});
            tri_cyc = cyc;
            pos = 0;
          end
        end else if (pos != 0) begin
          chk("seq_gap", 64'(pos), 64'd0);
          pos = 0;
        end
      end
    end
  end

  function automatic logic [63:0] last_cmp();
    if (cmps.size() == 0) return 'x;
    return cmps[cmps.size()-1];
  endfunction

  int cfg_cyc = 0;

  task automatic cfg(input logic [1:0] slot, input logic arm,
                     input logic [63:0] dl);
    cfg_wr_en    = 1'b1;
    cfg_slot     = slot;
    cfg_arm      = arm;
    cfg_deadline = dl;
    cfg_cyc      = cyc;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    m_armed[slot] = arm;
    if (arm) m_dl[slot] = dl;
  endtask

  task automatic quiet(string name);
    int idle = 0;
    int n = 0;
    while (idle < 3 && n < 300) begin
      @(posedge clk); #1;
      idle = busy ? 0 : idle + 1;
      n++;
    end
    chk(name, 64'(idle >= 3), 64'd1);
  endtask

  task automatic clear_pend();
    pend_clr = '1;
    @(posedge clk); #1;
    pend_clr = '0;
    m_pend = '0;
  endtask

  task automatic wait_lo_write(string name);
    int n = 0;
    while (!(mt_wr_en && mt_addr == 2'd2) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(mt_wr_en && mt_addr == 2'd2), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_wr_en = 1'b0;
    pend_clr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_armed = '0;
    m_pend = '0;
    cmps.delete();
  endtask

  initial begin
    int n0;
    int n;
    cfg_wr_en = 1'b0;
    cfg_slot = '0;
    cfg_arm = 1'b0;
    cfg_deadline = '0;
    pend_clr = '0;
    mt_time = '0;
    for (int i = 0; i < N; i++) m_dl[i] = '0;
    do_reset();

    // Idle after reset: no bus traffic.
    repeat (10) @(posedge clk);
    #1;
    chk("rst_writes", 64'(cmps.size()), 64'd0);
    chk("rst_wr_en", 64'(mt_wr_en), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_armed", 64'(armed), 64'd0);

    // Single slot programs and expires.
    cfg(2'd2, 1'b1, 64'h100);
    quiet("t2_quiet");
    chk("t2_ntri", 64'(cmps.size()), 64'd1);
    chk("t2_cmp", last_cmp(), 64'h100);
    chk("t2_cmp_model", last_cmp(), model_min());
    chk("t2_latency", 64'(tri_cyc - cfg_cyc), 64'(N + 4));
    chk("t2_armed", 64'(armed), 64'b0100);
    mt_time = 64'h100;
    model_expire();
    quiet("t2_quiet2");
    chk("t2_pending", 64'(pending), 64'b0100);
    chk("t2_pend_model", 64'(pending), 64'(m_pend));
    chk("t2_irq", 64'(irq), 64'd1);
    chk("t2_disarmed", 64'(armed), 64'd0);
    chk("t2_cmp_off", last_cmp(), 64'hFFFF_FFFF_FFFF_FFFF);
    clear_pend();
    chk("t2_clr", 64'(pending), 64'd0);
    chk("t2_clr_irq", 64'(irq), 64'd0);

    // Three slots, two sharing the earliest deadline.
    cfg(2'd0, 1'b1, 64'h500);
    cfg(2'd1, 1'b1, 64'h200);
    cfg(2'd3, 1'b1, 64'h200);
    quiet("t3_quiet");
    chk("t3_cmp", last_cmp(), 64'h200);
    chk("t3_cmp_model", last_cmp(), model_min());
    chk("t3_armed", 64'(armed), 64'b1011);
    mt_time = 64'h200;
    model_expire();
    quiet("t3_quiet2");
    chk("t3_pending", 64'(pending), 64'b1010);
    chk("t3_pend_model", 64'(pending), 64'(m_pend));
    chk("t3_armed2", 64'(armed), 64'b0001);
    chk("t3_cmp2", last_cmp(), 64'h500);
    chk("t3_cmp2_model", last_cmp(), model_min());
    clear_pend();

    // Past deadline, with a same-cycle pend_clr in EXPIRE.
    do_reset();
    mt_time = 64'h40;
    cfg(2'd0, 1'b1, 64'h10);
    n = 0;
    while (cmps.size() == 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_seq", 64'(cmps.size()), 64'd1);
    chk("t4_cmp", last_cmp(), 64'h10);
    n = 0;
    while (cyc < tri_cyc + 2 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_pend_before", 64'(pending), 64'd0);
    chk("t4_expire_busy", 64'(busy), 64'd1);
    pend_clr = 4'b0001;
    @(posedge clk); #1;
    pend_clr = '0;
    chk("t4_set_wins", 64'(pending), 64'b0001);
    chk("t4_irq", 64'(irq), 64'd1);
    model_expire();
    quiet("t4_quiet");
    chk("t4_pend_model", 64'(pending), 64'(m_pend));
    chk("t4_armed", 64'(armed), 64'd0);
    chk("t4_cmp_off", last_cmp(), 64'hFFFF_FFFF_FFFF_FFFF);
    clear_pend();

    // Config write landing in WR_LO forces a rescan.
    n0 = cmps.size();
    cfg(2'd1, 1'b1, 64'h1000);
    wait_lo_write("t5_lo_seen");
    cfg(2'd1, 1'b1, 64'h800);
    quiet("t5_quiet");
    chk("t5_ntri", 64'(cmps.size()), 64'(n0 + 2));
    chk("t5_first", cmps[n0], 64'h1000);
    chk("t5_final", last_cmp(), 64'h800);
    chk("t5_model", last_cmp(), model_min());

    // Disarm plus an all-ones deadline: never fires.
    cfg(2'd1, 1'b0, 64'h0);
    cfg(2'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    quiet("t6_quiet");
    chk("t6_armed", 64'(armed), 64'b1000);
    chk("t6_cmp", last_cmp(), 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_pend", 64'(pending), 64'd0);
    chk("t6_still_armed", 64'(armed), 64'b1000);

    // Reset while WR_LO is on the bus.
    n0 = cmps.size();
    cfg(2'd0, 1'b1, 64'h2000);
    wait_lo_write("t7_lo_seen");
    #1 rst = 1'b1;
    #1;
    chk("t7_wr_en", 64'(mt_wr_en), 64'd0);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_armed", 64'(armed), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_armed = '0;
    repeat (15) @(posedge clk);
    #1;
    chk("t7_aborted", 64'(cmps.size()), 64'(n0));
    chk("t7_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
